// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared register-address width, data width and writeback entry type
package core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback entries with per-slot rd export
//
// clk/rst          : clock, synchronous active-high reset
// push/push_entry  : enqueue request and payload (ignored when full unless popping)
// pop              : dequeue request (ignored when empty)
// full/empty/head  : occupancy flags and current head entry
// entry_valid/rd   : per-slot occupancy and destination, for hazard matching
module wb_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  wb_entry_t                           push_entry,
    input  logic                                pop,
    output logic                                full,
    output logic                                empty,
    output wb_entry_t                           head,
    output logic [DEPTH-1:0]                    entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_rd
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t          mem_q [DEPTH];
    wb_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               do_push;
    logic               do_pop;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign entry_valid = valid_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i] = mem_q[i].rd;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        // Pop clears before push sets so a full push+pop on the same slot stays valid.
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = PTR_W'(rd_ptr_q + 1'b1);
        end
        if (do_push) begin
            mem_d[wr_ptr_q]   = push_entry;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = PTR_W'(wr_ptr_q + 1'b1);
        end
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by valid_q/cnt_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_sequencer.sv
// rtl/wb_sequencer.sv - register file writeback arbiter with pending-load scoreboard
//
// i_clk/i_rst/i_clk_en      : clock, sync active-high reset, global advance enable
// i_alu_* / o_alu_ready     : buffered ALU results (valid/ready)
// i_ld_issue* / o_ld_issue_ready : load issue, blocked while its rd is pending
// i_ld_valid/i_ld_rd/i_ld_data : load responses, no backpressure, priority over ALU
// i_rsN_addr / o_rsN_busy   : decode hazard queries against current state
// o_rd_addr/o_rd_data/o_rd_write : registered register file write port
module wb_sequencer #(
    parameter int ALU_DEPTH = 2,
    parameter int XLEN      = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_en,
    input  logic            i_alu_valid,
    output logic            o_alu_ready,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic            i_ld_issue,
    output logic            o_ld_issue_ready,
    input  logic [4:0]      i_ld_issue_rd,
    input  logic            i_ld_valid,
    input  logic [4:0]      i_ld_rd,
    input  logic [XLEN-1:0] i_ld_data,
    input  logic [4:0]      i_rs1_addr,
    output logic            o_rs1_busy,
    input  logic [4:0]      i_rs2_addr,
    output logic            o_rs2_busy,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_rd_write
);

    import core_pkg::*;

    localparam int ENTRY_DATA_W = $bits(wb_entry_t) - REG_ADDR_W;

    wb_entry_t                              alu_entry;
    wb_entry_t                              fifo_head;
    logic                                   fifo_full;
    logic                                   fifo_empty;
    logic [ALU_DEPTH-1:0]                   fifo_valid;
    logic [ALU_DEPTH-1:0][REG_ADDR_W-1:0]   fifo_rd;
    logic                                   alu_push;
    logic                                   fifo_pop;
    logic                                   issue_take;

    logic                   rd_write_q, rd_write_d;
    logic [4:0]             rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]        rd_data_q, rd_data_d;
    logic [31:0]            pending_q, pending_d;
    logic                   rs1_hit, rs2_hit;

    assign o_rd_write = rd_write_q;
    assign o_rd_addr  = rd_addr_q;
    assign o_rd_data  = rd_data_q;

    assign o_alu_ready = !i_rst && !fifo_full;
    // A response to the same rd this cycle frees the slot, so re-issue is allowed.
    assign o_ld_issue_ready = !i_rst &&
        (!pending_q[i_ld_issue_rd] || (i_ld_valid && (i_ld_rd == i_ld_issue_rd)));

    assign alu_push   = i_clk_en && i_alu_valid && o_alu_ready;
    assign fifo_pop   = i_clk_en && !i_ld_valid && !fifo_empty;
    assign issue_take = i_clk_en && i_ld_issue && o_ld_issue_ready && (i_ld_issue_rd != '0);

    assign alu_entry.rd   = i_alu_rd;
    assign alu_entry.data = ENTRY_DATA_W'(i_alu_data);

    wb_fifo #(
        .DEPTH (ALU_DEPTH)
    ) u_fifo (
        .clk         (i_clk),
        .rst         (i_rst),
        .push        (alu_push),
        .push_entry  (alu_entry),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head        (fifo_head),
        .entry_valid (fifo_valid),
        .entry_rd    (fifo_rd)
    );

    always_comb begin
        rd_write_d = rd_write_q;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        pending_d  = pending_q;
        if (i_clk_en) begin
            if (i_ld_valid) begin
                rd_addr_d  = i_ld_rd;
                rd_data_d  = i_ld_data;
                rd_write_d = (i_ld_rd != '0);
                if (i_ld_rd != '0) begin
                    pending_d[i_ld_rd] = 1'b0;
                end
            end else if (!fifo_empty) begin
                rd_addr_d  = fifo_head.rd;
                rd_data_d  = XLEN'(fifo_head.data);
                rd_write_d = (fifo_head.rd != '0);
            end else begin
                rd_write_d = 1'b0;
            end
            // Applied after the clear so a same-rd issue and completion leaves it pending.
            if (issue_take) begin
                pending_d[i_ld_issue_rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_write_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            pending_q  <= '0;
        end else begin
            rd_write_q <= rd_write_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            pending_q  <= pending_d;
        end
    end

    // Hazard lookup uses registered state only: scoreboard, buffered ALU results,
    // and the write currently on the port.
    always_comb begin
        rs1_hit = pending_q[i_rs1_addr] || (rd_write_q && (rd_addr_q == i_rs1_addr));
        rs2_hit = pending_q[i_rs2_addr] || (rd_write_q && (rd_addr_q == i_rs2_addr));
        for (int i = 0; i < ALU_DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_rd[i] == i_rs1_addr)) rs1_hit = 1'b1;
            if (fifo_valid[i] && (fifo_rd[i] == i_rs2_addr)) rs2_hit = 1'b1;
        end
    end

    assign o_rs1_busy = !i_rst && (i_rs1_addr != '0) && rs1_hit;
    assign o_rs2_busy = !i_rst && (i_rs2_addr != '0) && rs2_hit;

endmodule

// File: tb/tb_wb_sequencer.sv
// tb/tb_wb_sequencer.sv - randomized and directed checks of wb_sequencer against a queue model
module tb_wb_sequencer;

    localparam int DEPTH = 2;

    logic        i_clk;
    logic        i_rst;
    logic        i_clk_en;
    logic        i_alu_valid;
    logic        o_alu_ready;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        i_ld_issue;
    logic        o_ld_issue_ready;
    logic [4:0]  i_ld_issue_rd;
    logic        i_ld_valid;
    logic [4:0]  i_ld_rd;
    logic [31:0] i_ld_data;
    logic [4:0]  i_rs1_addr;
    logic        o_rs1_busy;
    logic [4:0]  i_rs2_addr;
    logic        o_rs2_busy;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_write;

    wb_sequencer #(.ALU_DEPTH(DEPTH), .XLEN(32)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_clk_en         (i_clk_en),
        .i_alu_valid      (i_alu_valid),
        .o_alu_ready      (o_alu_ready),
        .i_alu_rd         (i_alu_rd),
        .i_alu_data       (i_alu_data),
        .i_ld_issue       (i_ld_issue),
        .o_ld_issue_ready (o_ld_issue_ready),
        .i_ld_issue_rd    (i_ld_issue_rd),
        .i_ld_valid       (i_ld_valid),
        .i_ld_rd          (i_ld_rd),
        .i_ld_data        (i_ld_data),
        .i_rs1_addr       (i_rs1_addr),
        .o_rs1_busy       (o_rs1_busy),
        .i_rs2_addr       (i_rs2_addr),
        .o_rs2_busy       (o_rs2_busy),
        .o_rd_addr        (o_rd_addr),
        .o_rd_data        (o_rd_data),
        .o_rd_write       (o_rd_write)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: ALU results in order, a pending bit per register,
    // and the write currently presented on the port.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    bit          m_pend[32];
    bit          m_write;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    function automatic bit m_busy(input logic [4:0] a);
        if (i_rst || a == 0) return 1'b0;
        if (m_pend[a]) return 1'b1;
        foreach (m_q[i]) if (m_q[i].rd == a) return 1'b1;
        return m_write && (m_addr == a);
    endfunction

    function automatic bit m_issue_ok();
        if (i_rst) return 1'b0;
        return !m_pend[i_ld_issue_rd] || (i_ld_valid && i_ld_rd == i_ld_issue_rd);
    endfunction

    task automatic compare();
        check("alu_ready", o_alu_ready, (!i_rst && m_q.size() < DEPTH));
        check("issue_ready", o_ld_issue_ready, m_issue_ok());
        check("rs1_busy", o_rs1_busy, m_busy(i_rs1_addr));
        check("rs2_busy", o_rs2_busy, m_busy(i_rs2_addr));
        check("rd_write", o_rd_write, m_write);
        if (m_write) begin
            check("rd_addr", o_rd_addr, m_addr);
            check("rd_data", o_rd_data, m_data);
        end
    endtask

    task automatic model_update();
        bit   alu_ok;
        bit   iss_ok;
        ent_t e;
        if (i_rst) begin
            m_q.delete();
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_write = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            return;
        end
        if (!i_clk_en) return;
        alu_ok = i_alu_valid && (m_q.size() < DEPTH);
        iss_ok = i_ld_issue && m_issue_ok();
        if (i_ld_valid) begin
            m_write = (i_ld_rd != 0);
            m_addr  = i_ld_rd;
            m_data  = i_ld_data;
            if (i_ld_rd != 0) m_pend[i_ld_rd] = 1'b0;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_write = (e.rd != 0);
            m_addr  = e.rd;
            m_data  = e.data;
        end else begin
            m_write = 1'b0;
        end
        if (alu_ok) begin
            e.rd = i_alu_rd;
            e.data = i_alu_data;
            m_q.push_back(e);
        end
        if (iss_ok && i_ld_issue_rd != 0) m_pend[i_ld_issue_rd] = 1'b1;
    endtask

    task automatic step();
        #1;
        compare();
        model_update();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_rst = 1'b0; i_clk_en = 1'b1;
        i_alu_valid = 1'b0; i_alu_rd = '0; i_alu_data = '0;
        i_ld_issue = 1'b0; i_ld_issue_rd = '0;
        i_ld_valid = 1'b0; i_ld_rd = '0; i_ld_data = '0;
    endtask

    initial begin
        idle();
        i_rs1_addr = '0;
        i_rs2_addr = '0;
        i_rst = 1'b1;
        model_update();
        @(posedge i_clk);
        #1;
        step();
        step();

        // Single ALU result: written two cycles after acceptance.
        idle(); i_rs1_addr = 5'd5;
        i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF;
        step();
        idle(); step();
        #1;
        check("deadbeef_write", o_rd_write, 1'b1);
        check("deadbeef_data", o_rd_data, 32'hDEADBEEF);
        check("deadbeef_busy", o_rs1_busy, 1'b1);
        step(); step();
        check("deadbeef_busy_end", o_rs1_busy, 1'b0);

        // Loads and ALU results every cycle: loads win, FIFO drains afterwards.
        for (int k = 0; k < 4; k++) begin
            idle();
            i_ld_valid = 1'b1; i_ld_rd = 5'(10 + k); i_ld_data = 32'hA000 + k;
            i_alu_valid = 1'b1; i_alu_rd = 5'(20 + k); i_alu_data = 32'hB000 + k;
            i_rs1_addr = 5'd20; i_rs2_addr = 5'd21;
            step();
        end
        idle();
        for (int k = 0; k < 4; k++) step();

        // Scoreboard: issue rd7, blocked re-issue, completion with same-cycle re-issue.
        idle(); i_rs1_addr = 5'd7; i_ld_issue = 1'b1; i_ld_issue_rd = 5'd7; step();
        idle(); i_rs1_addr = 5'd7; i_ld_issue = 1'b1; i_ld_issue_rd = 5'd7; step();
        idle(); i_ld_issue = 1'b1; i_ld_issue_rd = 5'd7;
        i_ld_valid = 1'b1; i_ld_rd = 5'd7; i_ld_data = 32'h1234; step();
        idle(); step();
        idle(); i_ld_valid = 1'b1; i_ld_rd = 5'd7; i_ld_data = 32'h5678; step();
        idle(); step();

        // x0 result is consumed but never written; rs2=0 never busy.
        idle(); i_rs2_addr = 5'd0;
        i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'hFFFFFFFF; step();
        idle(); for (int k = 0; k < 3; k++) step();

        // Fill the FIFO behind loads, then stall with a held load.
        for (int k = 0; k < 2; k++) begin
            idle();
            i_ld_valid = 1'b1; i_ld_rd = 5'd9; i_ld_data = 32'hC000 + k;
            i_alu_valid = 1'b1; i_alu_rd = 5'(12 + k); i_alu_data = 32'hD000 + k;
            i_rs1_addr = 5'd12; i_rs2_addr = 5'd9;
            step();
        end
        for (int k = 0; k < 3; k++) begin
            idle(); i_clk_en = 1'b0;
            i_ld_valid = 1'b1; i_ld_rd = 5'd14; i_ld_data = 32'hE000;
            i_alu_valid = 1'b1; i_alu_rd = 5'd15; i_alu_data = 32'hF000;
            i_rs1_addr = 5'd12; i_rs2_addr = 5'd13;
            step();
        end
        idle(); i_ld_valid = 1'b1; i_ld_rd = 5'd14; i_ld_data = 32'hE000; step();
        idle(); for (int k = 0; k < 3; k++) step();

        // Reset with two buffered entries and pending[3].
        idle(); i_ld_issue = 1'b1; i_ld_issue_rd = 5'd3; step();
        for (int k = 0; k < 2; k++) begin
            idle(); i_ld_valid = 1'b1; i_ld_rd = 5'd4; i_ld_data = 32'h44;
            i_alu_valid = 1'b1; i_alu_rd = 5'(16 + k); i_alu_data = 32'h1600 + k;
            step();
        end
        idle(); i_rst = 1'b1; step();
        idle(); i_rs1_addr = 5'd3; i_rs2_addr = 5'd16;
        for (int k = 0; k < 3; k++) step();

        // Randomized traffic over a small register range to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            i_rst         = ($urandom_range(0, 99) == 0);
            i_clk_en      = ($urandom_range(0, 7) != 0);
            i_alu_valid   = $urandom_range(0, 1);
            i_alu_rd      = 5'($urandom_range(0, 7));
            i_alu_data    = $urandom;
            i_ld_issue    = $urandom_range(0, 1);
            i_ld_issue_rd = 5'($urandom_range(0, 7));
            i_ld_valid    = ($urandom_range(0, 2) == 0);
            i_ld_rd       = 5'($urandom_range(0, 7));
            i_ld_data     = $urandom;
            i_rs1_addr    = 5'($urandom_range(0, 7));
            i_rs2_addr    = 5'($urandom_range(0, 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
